fifo_stream_writer: RTL and testbench
=====================================

FIFO_STREAM_WRITER -- requirements
Module: fifo_stream_writer

Interface
REQ-001 Parameter WIDTH, default 72, data word width in bits.
REQ-002 Parameter CNT_WIDTH, default 16, width of the written-word counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 s_data  input  WIDTH  upstream data word.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  block accepts a word; registered.
REQ-008 fifo_din  output  WIDTH  write data to the downstream small FIFO.
REQ-009 fifo_wr_en  output  1  write strobe to the downstream FIFO.
REQ-010 fifo_full  input  1  downstream FIFO full.
REQ-011 wr_count  output  CNT_WIDTH  count of words written to the FIFO, wrapping.
REQ-012 stall  output  1  high when a word is held and fifo_full blocks it.

Function
REQ-013 A transfer SHALL occur on any rising edge with s_valid=1 and s_ready=1; no other edge transfers.
REQ-014 The block SHALL hold up to 2 words in an internal skid store, in FIFO order.
REQ-015 Occupancy states: EMPTY (0 words), ONE (1), TWO (2).
REQ-016 fifo_wr_en SHALL be combinational: 1 iff state != EMPTY and fifo_full=0.
REQ-017 fifo_din SHALL always present the oldest held word; its value is don't-care in EMPTY.
REQ-018 Next occupancy SHALL equal occupancy + accept - fifo_wr_en.
REQ-019 Transitions: EMPTY->ONE on accept; ONE->EMPTY on write without accept; ONE stays ONE on accept and write together; ONE->TWO on accept without write; TWO->ONE on write. Every other case holds state.
REQ-020 On simultaneous accept and write in state ONE, the new word SHALL become the head on the next cycle.
REQ-021 In state TWO, the second word SHALL become the head after a write.
REQ-022 s_ready SHALL be a register loaded with (next occupancy < 2), so an accept never occurs in state TWO.
REQ-023 Minimum latency: a word accepted at edge t SHALL appear on fifo_din with fifo_wr_en=1 in the cycle following edge t when fifo_full=0.
REQ-024 Sustained throughput SHALL be 1 word/cycle while fifo_full=0 and s_valid=1.
REQ-025 Words SHALL never be dropped, duplicated or reordered, including while fifo_full toggles.
REQ-026 wr_count SHALL increment by 1 modulo 2^CNT_WIDTH on each edge with fifo_wr_en=1.
REQ-027 stall SHALL be 1 iff state != EMPTY and fifo_full=1.
REQ-028 s_data SHALL be ignored when s_valid=0.

Reset
REQ-029 On an edge with reset=1: state SHALL become EMPTY, s_ready 0, wr_count 0.
REQ-030 Held words SHALL be discarded on reset, including a reset asserted mid-transfer.
REQ-031 fifo_wr_en SHALL be 0 in the cycle after a reset edge.
REQ-032 s_ready SHALL become 1 at the first edge with reset=0.
REQ-033 The storage data registers SHALL NOT require reset.

Structure
REQ-034 The state encoding localparams (EMPTY/ONE/TWO, 2 bits) SHALL live in the shared FIFO-utilities constants include.
REQ-035 The block SHALL be a single module with no sub-modules; it pairs with the downstream small_fifo instantiated by the parent.

Verification
REQ-036 Reset held 3 cycles then released -> s_ready=0 until the first unreset edge, then 1; wr_count=0; fifo_wr_en=0.
REQ-037 Stream 0x01..0x08 back-to-back, fifo_full=0 -> fifo_din shows 0x01..0x08 on consecutive cycles, each one cycle after its accept; wr_count=8.
REQ-038 Accept 0xA1, 0xA2 with fifo_full=1 -> state TWO, s_ready=0, stall=1; release full -> writes 0xA1 then 0xA2, s_ready returns to 1.
REQ-039 Random s_valid and fifo_full toggling, 1000 words -> scoreboard shows exact in-order match; s_ready never 1 in TWO; no write while full.
REQ-040 Preload wr_count to 2^CNT_WIDTH-1 via 65535 writes, then 1 more write -> wr_count wraps to 0.
REQ-041 Reset asserted in state TWO -> next cycle EMPTY, fifo_wr_en=0, held words never written.

Source files
------------

// File: rtl/fifo_stream_writer_pkg.sv
// Shared constants for the FIFO stream writer: skid-store occupancy encoding.
package fifo_stream_writer_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = OCC_EMPTY,
      ST_ONE   = OCC_ONE,
      ST_TWO   = OCC_TWO
   } occ_e;

endpackage

// File: rtl/fifo_stream_writer.sv
// Two-entry skid store between a valid/ready stream and a small FIFO's write port.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no word held, fifo_din don't-care
// ST_ONE   | one word held in head_q
// ST_TWO   | head_q is oldest, tail_q next; s_ready is low
module fifo_stream_writer
   import fifo_stream_writer_pkg::*;
#(
   parameter int WIDTH     = 72,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [WIDTH-1:0]     fifo_din,
   output logic                 fifo_wr_en,
   input  logic                 fifo_full,
   output logic [CNT_WIDTH-1:0] wr_count,
   output logic                 stall
);

   occ_e                 state_q, state_d;
   logic                 s_ready_q;
   logic [CNT_WIDTH-1:0] wr_count_q;
   logic [WIDTH-1:0]     head_q, head_d;
   logic [WIDTH-1:0]     tail_q, tail_d;
   logic                 accept;
   logic                 wr;

   assign accept = s_valid & s_ready_q;
   assign wr     = (state_q != ST_EMPTY) & ~fifo_full;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               head_d  = s_data;
            end
         end
         ST_ONE: begin
            // Accept and write together: the outgoing head is replaced in place.
            if (accept && wr) begin
               head_d = s_data;
            end else if (accept) begin
               state_d = ST_TWO;
               tail_d  = s_data;
            end else if (wr) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (wr) begin
               state_d = ST_ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         s_ready_q  <= 1'b0;
         wr_count_q <= '0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d != ST_TWO);
         if (wr) begin
            wr_count_q <= wr_count_q + CNT_WIDTH'(1);
         end
      end
   end

   // Data storage carries no reset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   assign s_ready    = s_ready_q;
   assign fifo_din   = head_q;
   assign fifo_wr_en = wr;
   assign wr_count   = wr_count_q;
   assign stall      = (state_q != ST_EMPTY) & fifo_full;

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Bench for fifo_stream_writer: queue-based reference model checked every cycle plus directed literals.
module tb_fifo_stream_writer;

   localparam int WIDTH     = 72;
   localparam int CNT_WIDTH = 16;

   logic                 clk;
   logic                 reset;
   logic [WIDTH-1:0]     s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [WIDTH-1:0]     fifo_din;
   logic                 fifo_wr_en;
   logic                 fifo_full;
   logic [CNT_WIDTH-1:0] wr_count;
   logic                 stall;

   fifo_stream_writer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .wr_count   (wr_count),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the held words as a queue, the registered ready, the write count.
   logic [WIDTH-1:0]     mq[$];
   logic                 m_ready = 1'b0;
   logic [CNT_WIDTH-1:0] m_count = '0;
   bit                   m_valid = 1'b0;
   int                   wr_seen = 0;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_ready = 1'b0;
         m_count = '0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (mq.size() > 0 && !fifo_full) begin
            void'(mq.pop_front());
            m_count = m_count + 1'b1;
         end
         if (s_valid && m_ready) mq.push_back(s_data);
         m_ready = (mq.size() < 2);
      end
      if (!reset && fifo_wr_en) wr_seen++;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_s_ready", s_ready, m_ready);
         chk("m_wr_en", fifo_wr_en, (mq.size() > 0) && !fifo_full);
         chk("m_stall", stall, (mq.size() > 0) && fifo_full);
         chk("m_wr_count", wr_count, m_count);
         if (mq.size() > 0) chk("m_fifo_din", fifo_din, mq[0]);
      end
   end

   function automatic logic [WIDTH-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      reset = 1'b1; s_valid = 1'b0; fifo_full = 1'b0;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, cyc, seen0;
      bit acc;
      logic [WIDTH-1:0] cur;

      reset = 1'b1; s_valid = 1'b0; s_data = '0; fifo_full = 1'b0;

      // Reset held three edges, then released.
      @(negedge clk);
      chk("rst_ready", s_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_count", wr_count, 0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rel_ready_lo", s_ready, 0);
      @(negedge clk);
      chk("rel_ready_hi", s_ready, 1);

      // Back-to-back stream 1..8.
      @(posedge clk); #1; s_valid = 1'b1; s_data = 72'd1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) s_data = WIDTH'(i + 1); else s_valid = 1'b0;
         @(negedge clk);
         chk("stream_din", fifo_din, WIDTH'(i));
         chk("stream_wr_en", fifo_wr_en, 1);
      end
      @(negedge clk);
      chk("stream_count", wr_count, 8);

      // Two words under full, then drain.
      @(posedge clk); #1; fifo_full = 1'b1; s_valid = 1'b1; s_data = 72'hA1;
      @(posedge clk); #1; s_data = 72'hA2;
      @(posedge clk); #1; s_valid = 1'b0; s_data = 72'hFF;
      @(negedge clk);
      chk("two_ready", s_ready, 0);
      chk("two_stall", stall, 1);
      chk("two_wr_en", fifo_wr_en, 0);
      chk("two_din", fifo_din, 72'hA1);
      @(posedge clk); #1; fifo_full = 1'b0;
      @(negedge clk);
      chk("drain_din1", fifo_din, 72'hA1);
      chk("drain_wr1", fifo_wr_en, 1);
      @(negedge clk);
      chk("drain_din2", fifo_din, 72'hA2);
      chk("drain_ready", s_ready, 1);
      @(negedge clk);
      chk("drain_idle", fifo_wr_en, 0);
      chk("drain_count", wr_count, 10);

      // Random valid / full toggling, 1000 words.
      @(posedge clk); #1;
      seen0 = wr_seen;
      sent = 0; cyc = 0; cur = rnd_word();
      while (sent < 1000 && cyc < 20000) begin
         s_valid   = ($urandom_range(0, 9) < 7);
         fifo_full = ($urandom_range(0, 9) < 3);
         s_data    = s_valid ? cur : rnd_word();
         acc       = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            cur = rnd_word();
         end
         cyc++;
      end
      chk("rand_bound", sent, 1000);
      s_valid = 1'b0; fifo_full = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rand_written", wr_seen - seen0, 1000);

      // Counter wrap: 65535 writes then one more.
      do_reset(1);
      @(posedge clk); #1; s_valid = 1'b1; s_data = '0;
      repeat (65535) begin
         @(posedge clk); #1;
         s_data = s_data + 1'b1;
      end
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("wrap_max", wr_count, 16'hFFFF);
      @(posedge clk); #1; s_valid = 1'b1; s_data = 72'h55;
      @(posedge clk); #1; s_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("wrap_zero", wr_count, 0);

      // Reset while two words are held.
      do_reset(1);
      @(posedge clk); #1; fifo_full = 1'b1; s_valid = 1'b1; s_data = 72'hB1;
      @(posedge clk); #1; s_data = 72'hB2;
      @(posedge clk); #1; s_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_stall", stall, 1);
      chk("pre_rst_ready", s_ready, 0);
      @(posedge clk); #1; reset = 1'b1; fifo_full = 1'b0;
      seen0 = wr_seen;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_wr_en", fifo_wr_en, 0);
      chk("mid_rst_ready", s_ready, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_count", wr_count, 0);
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_no_wr", fifo_wr_en, 0);
      end
      chk("post_rst_writes", wr_seen - seen0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
